// File: rtl/dfd_cla_pkg.sv
// Shared types and sizing for the CLA destination action queue.
// Holds the action record, derived widths and the saturating increment helper.
package dfd_cla_pkg;

   localparam int WIDTH  = 8;
   localparam int LEVELS = 4;
   localparam int DEPTH  = 4;
   localparam int RPT_W  = 4;
   localparam int DROP_W = 8;

   localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [LVL_W-1:0] level;
      logic [RPT_W-1:0] rpt;
   } dst_action_t;

   localparam int ACT_W = $bits(dst_action_t);

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
      return (&value) ? value : value + DROP_W'(1);
   endfunction

endpackage

// File: rtl/dfd_dst_action_fifo_mem.sv
// DEPTH-entry action storage: one write port, async head read and, with
// DFD_DST_ACTION_QUEUE_COALESCE_EN, a tail read plus tail repeat-count update port.
module dfd_dst_action_fifo_mem
   import dfd_cla_pkg::*;
(
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [PTR_W-1:0] i_wr_ptr,
   input  logic [ACT_W-1:0] i_wr_data,
`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
   input  logic             i_rpt_en,
   input  logic [PTR_W-1:0] i_rpt_ptr,
   input  logic [RPT_W-1:0] i_rpt_val,
   output logic [ACT_W-1:0] o_tail_data,
`endif
   input  logic [PTR_W-1:0] i_rd_ptr,
   output logic [ACT_W-1:0] o_rd_data
);

   dst_action_t r_mem [DEPTH];

   // NOTE: storage carries no reset; the top gates every output with the
   // occupancy count, so stale entries are never observable and the array
   // stays a plain register file without a reset tree.
   always_ff @(posedge clk) begin
      if (i_wr_en)
         r_mem[i_wr_ptr] <= dst_action_t'(i_wr_data);
`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
      if (i_rpt_en)
         r_mem[i_rpt_ptr].rpt <= i_rpt_val;
`endif
   end

   assign o_rd_data = r_mem[i_rd_ptr];

`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
   assign o_tail_data = r_mem[i_rpt_ptr];
`endif

endmodule

// File: rtl/dfd_dst_action_queue.sv
// In-order queue between the destination priority mux and its consumer, with
// sticky overflow and saturating drop count. Optional DFD_DST_ACTION_QUEUE_COALESCE_EN.
module dfd_dst_action_queue
   import dfd_cla_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              queue_en,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [LVL_W-1:0]  in_level,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [LVL_W-1:0]  out_level,
   output logic [RPT_W-1:0]  out_rpt,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_cnt
);

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_cnt;

   logic              w_full;
   logic              w_empty;
   logic              w_req;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_coalesce;
   logic [ACT_W-1:0]  w_head_bits;
   dst_action_t       w_head;
   dst_action_t       w_wr_data;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_req   = in_valid & queue_en & ~clear;
   assign w_pop   = ~w_empty & out_ready;

   assign w_wr_data = '{data: in_data, level: in_level, rpt: '0};

`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
   logic [PTR_W-1:0] w_tail_ptr;
   logic [ACT_W-1:0] w_tail_bits;
   dst_action_t      w_tail;
   logic [RPT_W-1:0] w_rpt_next;

   assign w_tail_ptr = r_wr_ptr - PTR_W'(1);
   assign w_tail     = dst_action_t'(w_tail_bits);
   assign w_rpt_next = (&w_tail.rpt) ? w_tail.rpt : w_tail.rpt + RPT_W'(1);

   // A single entry being popped is both head and tail; it must not absorb the new action.
   assign w_coalesce = w_req & ~w_empty
                     & ~(w_pop & (r_count == CNT_W'(1)))
                     & (w_tail.data == in_data)
                     & (w_tail.level == in_level);
`else
   assign w_coalesce = 1'b0;
`endif

   assign w_push = w_req & ~w_coalesce & (~w_full | w_pop);
   assign w_drop = w_req & ~w_coalesce & w_full & ~w_pop;

   dfd_dst_action_fifo_mem u_mem (
      .clk         (clk),
      .i_wr_en     (w_push),
      .i_wr_ptr    (r_wr_ptr),
      .i_wr_data   (w_wr_data),
`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
      .i_rpt_en    (w_coalesce),
      .i_rpt_ptr   (w_tail_ptr),
      .i_rpt_val   (w_rpt_next),
      .o_tail_data (w_tail_bits),
`endif
      .i_rd_ptr    (r_rd_ptr),
      .o_rd_data   (w_head_bits)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= sat_inc(r_drop_cnt);
         end
      end
   end

   assign w_head    = dst_action_t'(w_head_bits);
   assign out_valid = ~w_empty;
   assign out_data  = w_empty ? '0 : w_head.data;
   assign out_level = w_empty ? '0 : w_head.level;

`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
   assign out_rpt   = w_empty ? '0 : w_head.rpt;
`else
   logic [RPT_W-1:0] w_unused_rpt;
   assign w_unused_rpt = w_head.rpt;
   assign out_rpt      = '0;
`endif

   assign count    = r_count;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_dfd_dst_action_queue.sv
// Scoreboard bench for dfd_dst_action_queue: stimulus queues expected head
// entries, a negedge monitor compares every accepted output against them.
module tb_dfd_dst_action_queue;
   import dfd_cla_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              queue_en = 1'b0;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic [WIDTH-1:0]  in_data = '0;
   logic [LVL_W-1:0]  in_level = '0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [WIDTH-1:0]  out_data;
   logic [LVL_W-1:0]  out_level;
   logic [RPT_W-1:0]  out_rpt;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic [DROP_W-1:0] drop_cnt;

   dst_action_t exp_q[$];
   dst_action_t mon_e;
   int n_cmp = 0;
   int n_bad = 0;

   dfd_dst_action_queue dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .queue_en  (queue_en),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_level  (in_level),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_level (out_level),
      .out_rpt   (out_rpt),
      .count     (count),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [WIDTH-1:0] d, input logic [LVL_W-1:0] l);
      in_valid = 1'b1;
      in_data  = d;
      in_level = l;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic exp_push(input logic [WIDTH-1:0] d, input logic [LVL_W-1:0] l,
                           input logic [RPT_W-1:0] r);
      dst_action_t e;
      e.data  = d;
      e.level = l;
      e.rpt   = r;
      exp_q.push_back(e);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (count != '0 && n < 20) begin
         tick();
         n++;
      end
      check("drain_count", 32'(count), 32'd0);
   endtask

   // Monitor: every accepted head entry is compared with the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got data %0h level %0h, expected no output",
                     out_data, out_level);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_data",  32'(out_data),  32'(mon_e.data));
            check("out_level", 32'(out_level), 32'(mon_e.level));
            check("out_rpt",   32'(out_rpt),   32'(mon_e.rpt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(count),     32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      @(negedge clk);
      reset_n  = 1'b1;
      queue_en = 1'b1;
      tick();

      // First push appears one edge later.
      exp_push(8'h5A, 2'd2, '0);
      drive_push(8'h5A, 2'd2);
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_out_data",  32'(out_data),  32'h5A);
      check("t1_out_level", 32'(out_level), 32'd2);
      check("t1_count",     32'(count),     32'd1);

      // Fill to DEPTH with a stalled consumer, then overflow once.
      exp_push(8'hB1, 2'd0, '0);
      drive_push(8'hB1, 2'd0);
      exp_push(8'hC2, 2'd1, '0);
      drive_push(8'hC2, 2'd1);
      exp_push(8'hD3, 2'd3, '0);
      drive_push(8'hD3, 2'd3);
      check("t2_count_full", 32'(count),    32'd4);
      check("t2_no_ovf",     32'(overflow), 32'd0);
      drive_push(8'hE4, 2'd1);
      check("t2_overflow",   32'(overflow), 32'd1);
      check("t2_drop_cnt",   32'(drop_cnt), 32'd1);
      check("t2_count_held", 32'(count),    32'd4);

      // Full with simultaneous pop: push accepted, no drop.
      exp_push(8'hF5, 2'd1, '0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hF5;
      in_level  = 2'd1;
      tick();
      in_valid = 1'b0;
      check("t3_count",    32'(count),    32'd4);
      check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
      wait_empty();
      out_ready = 1'b0;
      check("t3_drained_valid", 32'(out_valid), 32'd0);

      // Saturating drop counter, then clear racing a push.
      for (int i = 0; i < 4; i++)
         drive_push(8'(i + 1), 2'd0);
      in_valid = 1'b1;
      in_data  = 8'hEE;
      in_level = 2'd3;
      repeat (300) tick();
      in_valid = 1'b0;
      check("t4_drop_sat", 32'(drop_cnt), 32'hFF);
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_count",    32'(count),    32'd4);
      clear    = 1'b1;
      in_valid = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t4_clr_count",    32'(count),     32'd0);
      check("t4_clr_drop_cnt", 32'(drop_cnt),  32'd0);
      check("t4_clr_overflow", 32'(overflow),  32'd0);
      check("t4_clr_valid",    32'(out_valid), 32'd0);

      // queue_en low: nothing stored, nothing counted.
      queue_en = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h42;
      repeat (10) tick();
      in_valid = 1'b0;
      queue_en = 1'b1;
      check("t5_count",    32'(count),    32'd0);
      check("t5_drop_cnt", 32'(drop_cnt), 32'd0);
      check("t5_overflow", 32'(overflow), 32'd0);

      // Three identical actions with a stalled consumer.
`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
      exp_push(8'h11, 2'd1, 4'd2);
`else
      for (int i = 0; i < 3; i++)
         exp_push(8'h11, 2'd1, '0);
`endif
      in_valid = 1'b1;
      in_data  = 8'h11;
      in_level = 2'd1;
      repeat (3) tick();
      in_valid = 1'b0;
`ifdef DFD_DST_ACTION_QUEUE_COALESCE_EN
      check("t6_count",   32'(count),   32'd1);
      check("t6_out_rpt", 32'(out_rpt), 32'd2);
`else
      check("t6_count",   32'(count),   32'd3);
      check("t6_out_rpt", 32'(out_rpt), 32'd0);
`endif
      out_ready = 1'b1;
      wait_empty();
      out_ready = 1'b0;

      // Asynchronous reset mid-operation discards everything immediately.
      drive_push(8'h77, 2'd0);
      drive_push(8'h88, 2'd3);
      check("t7_count_pre", 32'(count), 32'd2);
      #2;
      reset_n = 1'b0;
      #1;
      check("t7_rst_count",    32'(count),     32'd0);
      check("t7_rst_valid",    32'(out_valid), 32'd0);
      check("t7_rst_out_data", 32'(out_data),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("t7_post_count", 32'(count), 32'd0);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
